// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel, redirect
// input from execute, and the valid/ready hand-off to decode.
interface if_stage_if #(
   parameter int XLEN = 64
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rsp_valid;
   logic [31:0]     imem_rsp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            id_valid;
   logic            id_ready;
   logic [31:0]     id_instr;
   logic [XLEN-1:0] id_pc;
   logic [6:0]      id_opcode;
   logic [3:0]      id_funct;

   modport master (
      output imem_req_valid, imem_addr, id_valid, id_instr, id_pc, id_opcode, id_funct,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
   );

   modport slave (
      input  imem_req_valid, imem_addr, id_valid, id_instr, id_pc, id_opcode, id_funct,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
   );
endinterface

// File: rtl/if_stage.sv
// RV64 instruction fetch stage: PC, outstanding-fetch tracking, instruction FIFO, redirect flush.
// Optional IF_NOP_BUBBLE_EN zeroes id_instr/id_opcode/id_funct whenever id_valid is low.
module if_stage #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 2
) (
   input logic        clk,
   input logic        rst,
   if_stage_if.master bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   logic [XLEN-1:0] pc;
   logic            rst_cycle;
   logic [CW-1:0]   outstanding, drop_cnt, fifo_count;
   logic [PW-1:0]   rd_ptr, wr_ptr, tag_rd, tag_wr;
   logic [31:0]     fifo_instr [DEPTH];
   logic [XLEN-1:0] fifo_pc    [DEPTH];
   logic [XLEN-1:0] tag_pc     [DEPTH];
   logic            id_valid_q;
   logic [31:0]     id_instr_q;
   logic [XLEN-1:0] id_pc_q;
   logic [31:0]     id_instr_w;

   logic            req_fire, rsp_drop, push, pop;
   logic [CW-1:0]   outstanding_next, count_after_pop, count_next;
   logic [PW-1:0]   rd_ptr_next;
   logic [31:0]     head_instr_next;
   logic [XLEN-1:0] head_pc_next;

   assign bus.imem_req_valid = !rst_cycle && !bus.redirect_valid &&
                               (({1'b0, fifo_count} + {1'b0, outstanding}) < {1'b0, DEPTH_C});
   assign bus.imem_addr      = pc;
   assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
   assign rsp_drop           = bus.imem_rsp_valid && (drop_cnt != '0);
   assign push               = bus.imem_rsp_valid && !rsp_drop && !bus.redirect_valid;
   assign pop                = id_valid_q && bus.id_ready && !bus.redirect_valid;

   // Next-cycle FIFO head: a push into a FIFO that is empty after this pop bypasses storage.
   always_comb begin
      outstanding_next = outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      count_after_pop  = fifo_count - CW'(pop);
      count_next       = bus.redirect_valid ? '0 : count_after_pop + CW'(push);
      rd_ptr_next      = bus.redirect_valid ? '0 : rd_ptr + PW'(pop);
      head_instr_next  = fifo_instr[rd_ptr_next];
      head_pc_next     = fifo_pc[rd_ptr_next];
      if (count_after_pop == '0) begin
         head_instr_next = bus.imem_rsp_data;
         head_pc_next    = tag_pc[tag_rd];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC & ALIGN_MASK;
         rst_cycle   <= 1'b1;
         outstanding <= '0;
         drop_cnt    <= '0;
         fifo_count  <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         tag_rd      <= '0;
         tag_wr      <= '0;
         id_valid_q  <= 1'b0;
         id_instr_q  <= '0;
         id_pc_q     <= '0;
      end else begin
         rst_cycle   <= 1'b0;
         outstanding <= outstanding_next;
         fifo_count  <= count_next;
         rd_ptr      <= rd_ptr_next;
         if (req_fire) tag_wr <= tag_wr + PW'(1);
         if (bus.imem_rsp_valid) tag_rd <= tag_rd + PW'(1);
         // Every request still in flight at a redirect belongs to the wrong path.
         if (bus.redirect_valid) begin
            drop_cnt <= outstanding_next;
            pc       <= bus.redirect_pc & ALIGN_MASK;
            wr_ptr   <= '0;
         end else begin
            if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
            if (req_fire) pc <= pc + XLEN'(4);
            if (push) wr_ptr <= wr_ptr + PW'(1);
         end
         id_valid_q <= (count_next != '0);
         if (count_next != '0) begin
            id_instr_q <= head_instr_next;
            id_pc_q    <= head_pc_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire) tag_pc[tag_wr] <= bus.imem_addr;
      if (push) begin
         fifo_instr[wr_ptr] <= bus.imem_rsp_data;
         fifo_pc[wr_ptr]    <= tag_pc[tag_rd];
      end
   end

   assert property (@(posedge clk) disable iff (rst) !(push && !pop && (fifo_count == DEPTH_C)));

`ifdef IF_NOP_BUBBLE_EN
   assign id_instr_w = id_valid_q ? id_instr_q : 32'h0;
`else
   assign id_instr_w = id_instr_q;
`endif

   assign bus.id_valid  = id_valid_q;
   assign bus.id_instr  = id_instr_w;
   assign bus.id_pc     = id_pc_q;
   assign bus.id_opcode = id_instr_w[6:0];
   assign bus.id_funct  = {id_instr_w[30], id_instr_w[14:12]};

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: in-order memory model with variable latency and a
// PC scoreboard filled on each accepted fetch and drained at each decode pop.
module tb_if_stage;

   localparam int          XLEN     = 64;
   localparam logic [63:0] RESET_PC = 64'h1000;
   localparam int          DEPTH    = 2;

   typedef struct {
      logic [63:0] addr;
      int          due;
   } pend_t;

   logic        clk = 1'b0;
   logic        rst;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   int          accepts = 0;
   int          consumed = 0;
   int          base;
   int          first_acc;
   logic [63:0] exp_fetch = RESET_PC;
   logic [63:0] last_pc = '0;
   logic [63:0] last_acc = '0;
   logic [63:0] sb_pc;
   logic [63:0] exp_q[$];
   pend_t       pend[$];
   logic [3:0]  rdy_pat = 4'b1001;

   always #5 clk = ~clk;

   if_stage_if #(.XLEN(XLEN)) bus();

   if_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   function automatic logic [31:0] mem_data(input logic [63:0] a);
      return {a[26:2], 7'h13};
   endfunction

   function automatic logic [3:0] funct_of(input logic [31:0] d);
      return {d[30], d[14:12]};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs set here apply to the current cycle; returns 2 time units after the next edge.
   task automatic applyStimulus(input logic req_rdy, input logic id_rdy);
      bus.imem_req_ready = req_rdy;
      bus.id_ready       = id_rdy;
      @(posedge clk);
      #2;
   endtask

   // Instruction memory: in-order responses, shares the stage's reset.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pend.delete();
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = '0;
      end else begin
         cyc++;
         #1;
         if (pend.size() != 0 && pend[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_data(pend[0].addr);
         end else begin
            bus.imem_rsp_valid = 1'b0;
         end
      end
   end

   // Mid-cycle monitor: decides which handshakes complete at the coming edge.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         exp_fetch = RESET_PC;
      end else begin
         if (bus.imem_rsp_valid && pend.size() != 0) void'(pend.pop_front());
         if (bus.redirect_valid) begin
            checkOutput("req_during_redirect", 64'(bus.imem_req_valid), 64'd0);
            exp_q.delete();
            exp_fetch = bus.redirect_pc & ~64'h3;
         end else begin
            if (bus.id_valid && bus.id_ready) begin
               checkOutput("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0) begin
                  sb_pc = exp_q.pop_front();
                  checkOutput("sb_id_pc", bus.id_pc, sb_pc);
                  checkOutput("sb_id_instr", 64'(bus.id_instr), 64'(mem_data(sb_pc)));
                  checkOutput("sb_id_opcode", 64'(bus.id_opcode), 64'h13);
                  checkOutput("sb_id_funct", 64'(bus.id_funct), 64'(funct_of(mem_data(sb_pc))));
                  last_pc = sb_pc;
                  consumed++;
               end
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
               checkOutput("imem_addr", bus.imem_addr, exp_fetch);
               exp_q.push_back(exp_fetch);
               pend.push_back('{bus.imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
               last_acc = bus.imem_addr;
               exp_fetch += 64'd4;
               accepts++;
            end
         end
      end
   end

   initial begin
      rst                = 1'b1;
      bus.imem_req_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.id_ready       = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      checkOutput("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
      checkOutput("rst_id_valid", 64'(bus.id_valid), 64'd0);
      checkOutput("rst_id_instr", 64'(bus.id_instr), 64'd0);
      checkOutput("rst_id_pc", bus.id_pc, 64'd0);
      rst = 1'b0;

      // first fetch and its latency to decode
      for (int i = 0; i < 10 && !bus.imem_req_valid; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("first_req_seen", 64'(bus.imem_req_valid), 64'd1);
      checkOutput("first_addr", bus.imem_addr, 64'h1000);
      first_acc = cyc;
      for (int i = 0; i < 10 && !bus.id_valid; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("first_valid_latency", 64'(cyc - first_acc), 64'd2);
      checkOutput("first_id_pc", bus.id_pc, 64'h1000);
      checkOutput("first_id_opcode", 64'(bus.id_opcode), 64'h13);
      checkOutput("first_id_funct", 64'(bus.id_funct), 64'(funct_of(mem_data(64'h1000))));

      // decode stalled: capacity caps fetches at DEPTH
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b0);
         checkOutput("stall_id_pc", bus.id_pc, 64'h1000);
      end
      checkOutput("stall_accepts", 64'(accepts), 64'(DEPTH));
      checkOutput("stall_req_valid", 64'(bus.imem_req_valid), 64'd0);
      checkOutput("stall_id_instr", 64'(bus.id_instr), 64'(mem_data(64'h1000)));

      for (int i = 0; i < 20 && accepts < 3; i++) applyStimulus(1'b1, 1'b1);
      checkOutput("resume_addr", last_acc, 64'h1008);

      // drain, then look at the idle outputs
      for (int i = 0; i < 40 && (bus.id_valid || pend.size() != 0); i++) applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("drained_valid", 64'(bus.id_valid), 64'd0);
      checkOutput("idle_id_pc", bus.id_pc, last_pc);
`ifdef IF_NOP_BUBBLE_EN
      checkOutput("idle_id_instr", 64'(bus.id_instr), 64'd0);
      checkOutput("idle_id_opcode", 64'(bus.id_opcode), 64'd0);
`else
      checkOutput("idle_id_instr", 64'(bus.id_instr), 64'(mem_data(last_pc)));
      checkOutput("idle_id_opcode", 64'(bus.id_opcode), 64'h13);
`endif

      // redirect with two fetches in flight
      lat_min = 4;
      lat_max = 4;
      for (int i = 0; i < 20 && pend.size() != 2; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("two_outstanding", 64'(pend.size()), 64'd2);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h2002;
      applyStimulus(1'b1, 1'b1);
      bus.redirect_valid = 1'b0;
      checkOutput("redirect_valid_after", 64'(bus.id_valid), 64'd0);
      for (int i = 0; i < 40 && !bus.id_valid; i++) applyStimulus(1'b1, 1'b1);
      checkOutput("redirect_first_pc", bus.id_pc, 64'h2000);
      checkOutput("redirect_first_instr", 64'(bus.id_instr), 64'(mem_data(64'h2000)));

      // redirect coinciding with a response and a decode pop
      lat_min = 1;
      lat_max = 1;
      for (int i = 0; i < 30 && !(bus.imem_rsp_valid && bus.id_valid); i++) applyStimulus(1'b1, 1'b1);
      checkOutput("rsp_and_pop_seen", 64'(bus.imem_rsp_valid && bus.id_valid), 64'd1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h3000;
      applyStimulus(1'b1, 1'b1);
      bus.redirect_valid = 1'b0;
      checkOutput("coincide_valid_after", 64'(bus.id_valid), 64'd0);
      for (int i = 0; i < 20 && !bus.id_valid; i++) applyStimulus(1'b1, 1'b1);
      checkOutput("coincide_first_pc", bus.id_pc, 64'h3000);

      // streaming with stuttering memory ready and random latency
      lat_max = 3;
      base = consumed;
      for (int i = 0; i < 3000 && (consumed - base) < 100; i++)
         applyStimulus(rdy_pat[i % 4], ($urandom_range(3, 0) != 0));
      checkOutput("stream_100", 64'((consumed - base) >= 100), 64'd1);

      // reset with one fetch in flight
      lat_min = 6;
      lat_max = 6;
      for (int i = 0; i < 40 && pend.size() != 0; i++) applyStimulus(1'b0, 1'b1);
      for (int i = 0; i < 10 && pend.size() != 1; i++) applyStimulus(1'b1, 1'b1);
      checkOutput("one_outstanding", 64'(pend.size()), 64'd1);
      rst = 1'b1;
      #1;
      checkOutput("midrst_req_valid", 64'(bus.imem_req_valid), 64'd0);
      checkOutput("midrst_id_valid", 64'(bus.id_valid), 64'd0);
      checkOutput("midrst_id_instr", 64'(bus.id_instr), 64'd0);
      checkOutput("midrst_id_pc", bus.id_pc, 64'd0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      lat_min = 1;
      lat_max = 1;
      for (int i = 0; i < 20 && !bus.id_valid; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("restart_id_pc", bus.id_pc, RESET_PC);
      checkOutput("restart_id_instr", 64'(bus.id_instr), 64'(mem_data(RESET_PC)));
      repeat (20) applyStimulus(1'b1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
